byte_alu_dma: RTL
=================

BYTE_ALU_DMA -- requirements
Module: byte_alu_dma

Interface
- REQ-001 Parameter DATA_WIDTH, default 64: Avalon-MM data width in bits; SHALL be a multiple of 8.
- REQ-002 Parameter ADDR_WIDTH, default 10: word-address width of both masters and of length_i.
- REQ-003 Parameter BYTE_CNT, default DATA_WIDTH/8: bytes per word and byteenable width.
- REQ-004 Parameter MAX_PENDING, default 4: limit on read words outstanding or buffered; a power of 2, ≥2.
- REQ-005 One clock, clk_i; reset srst_i is synchronous and active-high.
- REQ-006 clk_i  in  1  clock.
- REQ-007 srst_i  in  1  synchronous active-high reset.
- REQ-008 run_i  in  1  start pulse; sampled only in IDLE.
- REQ-009 base_addr_i  in  ADDR_WIDTH  source word address.
- REQ-010 dst_addr_i  in  ADDR_WIDTH  destination word address.
- REQ-011 length_i  in  ADDR_WIDTH  job length in bytes.
- REQ-012 op_i  in  2  byte operation: 00 add, 01 sub, 10 xor, 11 pass.
- REQ-013 operand_i  in  8  byte operand for op_i.
- REQ-014 waitrequest_o  out  1  high while a job is busy.
- REQ-015 amm_rd_address_o / amm_rd_read_o  out  ADDR_WIDTH / 1  read command.
- REQ-016 amm_rd_readdata_i / amm_rd_readdatavalid_i / amm_rd_waitrequest_i  in  DATA_WIDTH / 1 / 1  read response and stall.
- REQ-017 amm_wr_address_o / amm_wr_write_o / amm_wr_writedata_o / amm_wr_byteenable_o  out  ADDR_WIDTH / 1 / DATA_WIDTH / BYTE_CNT  write command.
- REQ-018 amm_wr_waitrequest_i  in  1  write stall.

Function
- REQ-019 FSM states: IDLE, BUSY. IDLE→BUSY on run_i=1. BUSY→IDLE the cycle after the last write is accepted. For a zero-length job, BUSY→IDLE after exactly one cycle.
- REQ-020 On run_i in IDLE, the block SHALL latch all config inputs. waitrequest_o=1 from the next cycle until the return to IDLE. run_i in BUSY SHALL be ignored.
- REQ-021 Word count N = ceil(length_i/BYTE_CNT), computed from the latched value. length_i=0 SHALL issue no read or write.
- REQ-022 Read k (0≤k<N) SHALL use address base+k, modulo 2^ADDR_WIDTH.
- REQ-023 A read SHALL be issued only if issued-but-unreturned plus buffered words < MAX_PENDING.
- REQ-024 While amm_rd_waitrequest_i=1, amm_rd_read_o and amm_rd_address_o SHALL hold. A read is accepted on read=1 & waitrequest=0.
- REQ-025 Each readdatavalid word SHALL enter an internal FIFO of depth MAX_PENDING, in order. readdatavalid with nothing outstanding SHALL be ignored. The FIFO never overflows, by REQ-023.
- REQ-026 Write j SHALL present the FIFO head, transformed bytewise mod 256 (add: b+operand; sub: b−operand; xor: b^operand; pass: b), at address dst+j modulo 2^ADDR_WIDTH.
- REQ-027 amm_wr_byteenable_o SHALL be all ones, except on word N−1 when R=length mod BYTE_CNT≠0, where it SHALL be (1<<R)−1. Disabled bytes still carry transformed data.
- REQ-028 While amm_wr_waitrequest_i=1, write, address, data and byteenable SHALL hold. On acceptance the FIFO pops. Push and pop in the same cycle SHALL keep occupancy unchanged.
- REQ-029 Reads and writes SHALL proceed concurrently. Minimum latency from an accepted read with 1-cycle readdatavalid to its write SHALL be 1 cycle (registered FIFO output).
- REQ-030 In IDLE, amm_rd_read_o=0 and amm_wr_write_o=0.

Reset
- REQ-031 srst_i=1 at any edge SHALL set IDLE, waitrequest_o=0, amm_rd_read_o=0, amm_wr_write_o=0, all addresses, data and byteenable=0, and FIFO and counters cleared.
- REQ-032 Reset mid-job SHALL abort the job. Later readdatavalid for reads issued before reset SHALL be ignored, and no write SHALL follow.

Verification
- REQ-033 DATA_WIDTH=64, base=0x10, dst=0x20, length=21, op=add, operand=1, no stalls → 3 reads at 0x10–0x12; 3 writes at 0x20–0x22 with each byte = read byte+1; byteenables FF, FF, 1F; waitrequest_o falls the cycle after the third write.
- REQ-034 length=16, op=xor, operand=0xFF, write waitrequest toggling 2 on / 2 off → 2 writes, byteenable FF both, data = ~readdata, signals stable during every stall.
- REQ-035 base=0x3FC, length=45, op=sub, operand=3 → read addresses 3FC, 3FD, 3FE, 3FF, 000, 001; last byteenable 1F; bytes = rd−3 mod 256.
- REQ-036 MAX_PENDING=4, length=80, readdatavalid delayed 6 cycles → never more than 4 unreturned or buffered words; 10 writes in order.
- REQ-037 length=0 → waitrequest_o high exactly 1 cycle; no read or write.
- REQ-038 srst_i pulsed after the 2nd of 5 writes → all outputs 0 next cycle; late readdatavalid causes no write; a new run_i job completes correctly.

Source files
------------

// File: rtl/byte_alu_dma_if.sv
// Avalon-MM read and write master bundle for byte_alu_dma.
//   master: DMA side (drives read/write commands, receives data and stalls)
//   slave : memory side (mirror directions)
// Signal names keep the original port names of byte_alu_dma.
interface byte_alu_dma_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BYTE_CNT   = DATA_WIDTH / 8
) ();
  logic [ADDR_WIDTH-1:0] amm_rd_address_o;
  logic                  amm_rd_read_o;
  logic [DATA_WIDTH-1:0] amm_rd_readdata_i;
  logic                  amm_rd_readdatavalid_i;
  logic                  amm_rd_waitrequest_i;

  logic [ADDR_WIDTH-1:0] amm_wr_address_o;
  logic                  amm_wr_write_o;
  logic [DATA_WIDTH-1:0] amm_wr_writedata_o;
  logic [BYTE_CNT-1:0]   amm_wr_byteenable_o;
  logic                  amm_wr_waitrequest_i;

  modport master (
    output amm_rd_address_o, amm_rd_read_o,
    input  amm_rd_readdata_i, amm_rd_readdatavalid_i, amm_rd_waitrequest_i,
    output amm_wr_address_o, amm_wr_write_o, amm_wr_writedata_o, amm_wr_byteenable_o,
    input  amm_wr_waitrequest_i
  );

  modport slave (
    input  amm_rd_address_o, amm_rd_read_o,
    output amm_rd_readdata_i, amm_rd_readdatavalid_i, amm_rd_waitrequest_i,
    input  amm_wr_address_o, amm_wr_write_o, amm_wr_writedata_o, amm_wr_byteenable_o,
    output amm_wr_waitrequest_i
  );
endinterface

// File: rtl/byte_alu_dma.sv
// byte_alu_dma: copies length_i bytes (rounded up to whole words) from
// base_addr_i to dst_addr_i, applying a bytewise add/sub/xor/pass with
// operand_i. Reads and writes run concurrently through a small FIFO.
// Ports:
//   clk_i, srst_i          clock, synchronous active-high reset
//   run_i                  start pulse (sampled in IDLE only)
//   base_addr_i/dst_addr_i source / destination word address
//   length_i               job length in bytes
//   op_i, operand_i        byte operation and operand
//   waitrequest_o          high while a job is busy
//   amm                    Avalon-MM read and write masters
module byte_alu_dma #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned BYTE_CNT    = DATA_WIDTH / 8,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  run_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [ADDR_WIDTH-1:0] length_i,
  input  logic [1:0]            op_i,
  input  logic [7:0]            operand_i,
  output logic                  waitrequest_o,
  byte_alu_dma_if.master        amm
);
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned PW = $clog2(MAX_PENDING) + 1;
  localparam int unsigned FW = $clog2(MAX_PENDING);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, dst_q, len_q;
  logic [1:0]            op_q;
  logic [7:0]            operand_q;
  logic [CW-1:0]         n_words, len_rem, rd_idx_q, wr_idx_q, wr_done_q;
  logic [BYTE_CNT:0]     rem_mask;
  logic [BYTE_CNT-1:0]   last_be;
  logic [PW-1:0]         pend_q, pend_after, unret_q, fifo_cnt_q;
  logic [FW-1:0]         wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] fifo_mem [MAX_PENDING];
  logic [DATA_WIDTH-1:0] wr_src;
  logic busy, rd_accept, wr_accept, rdv_ok, rd_launch, wr_slot;
  logic wr_from_fifo, wr_bypass, fifo_push, last_wr;

  function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] d,
                                                  input logic [1:0] op,
                                                  input logic [7:0] k);
    logic [DATA_WIDTH-1:0] r;
    logic [7:0]            b;
    r = '0;
    for (int unsigned i = 0; i < BYTE_CNT; i++) begin
      b = d[i*8 +: 8];
      unique case (op)
        2'b00:   b = b + k;
        2'b01:   b = b - k;
        2'b10:   b = b ^ k;
        default: b = b;
      endcase
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  always_comb begin
    busy       = (state_q == BUSY);
    n_words    = (CW'(len_q) + CW'(BYTE_CNT - 1)) / CW'(BYTE_CNT);
    len_rem    = CW'(len_q) % CW'(BYTE_CNT);
    rem_mask   = ((BYTE_CNT+1)'(1) << len_rem) - (BYTE_CNT+1)'(1);
    last_be    = (len_rem == '0) ? '1 : rem_mask[BYTE_CNT-1:0];
    rd_accept  = amm.amm_rd_read_o & ~amm.amm_rd_waitrequest_i;
    wr_accept  = amm.amm_wr_write_o & ~amm.amm_wr_waitrequest_i;
    // Responses with nothing outstanding (e.g. from reads issued before a reset) are dropped.
    rdv_ok     = amm.amm_rd_readdatavalid_i & (unret_q != '0);
    // pend counts words from read launch until their write is accepted, so the
    // limit also covers a read currently presented but not yet accepted.
    pend_after = pend_q - PW'(wr_accept);
    rd_launch  = busy & (~amm.amm_rd_read_o | rd_accept) & (rd_idx_q < n_words)
               & (pend_after < PW'(MAX_PENDING));
    // The write command register acts as the FIFO output stage; when the FIFO
    // is empty an arriving word bypasses straight into it.
    wr_slot      = busy & (~amm.amm_wr_write_o | wr_accept);
    wr_from_fifo = wr_slot & (fifo_cnt_q != '0);
    wr_bypass    = wr_slot & (fifo_cnt_q == '0) & rdv_ok;
    fifo_push    = rdv_ok & ~wr_bypass;
    wr_src       = wr_from_fifo ? fifo_mem[rptr_q] : amm.amm_rd_readdata_i;
    last_wr      = wr_accept & (wr_done_q == n_words - CW'(1));
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run_i) state_d = BUSY;
      BUSY:    if ((n_words == '0) || last_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    waitrequest_o = (state_q == BUSY);
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_mem[wptr_q] <= amm.amm_rd_readdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      base_q    <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      op_q      <= '0;
      operand_q <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      wr_done_q <= '0;
      pend_q    <= '0;
      unret_q   <= '0;
      fifo_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      amm.amm_rd_read_o       <= 1'b0;
      amm.amm_rd_address_o    <= '0;
      amm.amm_wr_write_o      <= 1'b0;
      amm.amm_wr_address_o    <= '0;
      amm.amm_wr_writedata_o  <= '0;
      amm.amm_wr_byteenable_o <= '0;
    end else begin
      if (!busy && run_i) begin
        base_q    <= base_addr_i;
        dst_q     <= dst_addr_i;
        len_q     <= length_i;
        op_q      <= op_i;
        operand_q <= operand_i;
        rd_idx_q  <= '0;
        wr_idx_q  <= '0;
        wr_done_q <= '0;
      end

      if (rd_launch) begin
        amm.amm_rd_read_o    <= 1'b1;
        amm.amm_rd_address_o <= base_q + rd_idx_q[ADDR_WIDTH-1:0];
        rd_idx_q             <= rd_idx_q + CW'(1);
      end else if (rd_accept) begin
        amm.amm_rd_read_o <= 1'b0;
      end

      pend_q     <= pend_after + PW'(rd_launch);
      unret_q    <= unret_q + PW'(rd_accept) - PW'(rdv_ok);
      fifo_cnt_q <= fifo_cnt_q + PW'(fifo_push) - PW'(wr_from_fifo);
      if (fifo_push)    wptr_q <= wptr_q + FW'(1);
      if (wr_from_fifo) rptr_q <= rptr_q + FW'(1);

      if (wr_from_fifo || wr_bypass) begin
        amm.amm_wr_write_o      <= 1'b1;
        amm.amm_wr_address_o    <= dst_q + wr_idx_q[ADDR_WIDTH-1:0];
        amm.amm_wr_writedata_o  <= xform(wr_src, op_q, operand_q);
        amm.amm_wr_byteenable_o <= (wr_idx_q == n_words - CW'(1)) ? last_be : '1;
        wr_idx_q                <= wr_idx_q + CW'(1);
      end else if (wr_accept) begin
        amm.amm_wr_write_o <= 1'b0;
      end

      if (wr_accept) wr_done_q <= wr_done_q + CW'(1);
    end
  end
endmodule
